// File: rtl/alfa_desc.sv
// alfa_desc -- word-class glyph decoder.
//
// Classifies a three-note word (notas1..notas3 plus the Tom flag) as idle,
// adjective, comparative, adverb or error, and drives the matching
// 7-segment glyph. The glyph is registered, giving one cycle of latency.
//
// Ports:
//   clk            in   sole clock, rising edge
//   reset          in   synchronous, active-high; loads the blank glyph
//   Tom            in   tone flag for the word (1 = raised tone)
//   notas1..3      in   3-bit note codes (000 none, 001 do .. 111 si)
//   saida1..saida7 out  segments a..g, registered
//
// Configuration macro:
//   ALFA_DESC_ACTIVE_LOW_EN  defined -> all segments inverted (common anode),
//                            including the reset/blank value.

module alfa_desc (
   input  logic       clk,
   input  logic       reset,
   input  logic       Tom,
   input  logic [2:0] notas1,
   input  logic [2:0] notas2,
   input  logic [2:0] notas3,
   output logic       saida1,
   output logic       saida2,
   output logic       saida3,
   output logic       saida4,
   output logic       saida5,
   output logic       saida6,
   output logic       saida7
);

   typedef enum logic [2:0] {
      CLS_IDLE,
      CLS_ADJ,
      CLS_COMP,
      CLS_ADV,
      CLS_ERR
   } word_cls_e;

   localparam logic [2:0] NOTE_NONE = 3'b000;
   localparam logic [2:0] NOTE_DO   = 3'b001;
   localparam logic [2:0] NOTE_RE   = 3'b010;
   localparam logic [2:0] NOTE_LA   = 3'b110;
   localparam logic [2:0] NOTE_SI   = 3'b111;

   // Glyphs in active-high form, bit 6 = segment a ... bit 0 = segment g.
   localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
   localparam logic [6:0] GLYPH_A     = 7'b1110111;
   localparam logic [6:0] GLYPH_C     = 7'b1001110;
   localparam logic [6:0] GLYPH_D     = 7'b0111101;
   localparam logic [6:0] GLYPH_E     = 7'b1001111;

`ifdef ALFA_DESC_ACTIVE_LOW_EN
   localparam logic [6:0] POL_MASK = '1;
`else
   localparam logic [6:0] POL_MASK = '0;
`endif

   localparam logic [6:0] SEG_RESET = GLYPH_BLANK ^ POL_MASK;

   word_cls_e  word_cls;
   logic [6:0] seg_d;
   logic [6:0] seg_q;

   // Priority classification; first matching rule wins.
   always_comb begin
      word_cls = CLS_ERR;
      if (notas1 == NOTE_NONE && notas2 == NOTE_NONE && notas3 == NOTE_NONE)
         word_cls = CLS_IDLE;
      else if (notas1 == NOTE_NONE || notas2 == NOTE_NONE)
         word_cls = CLS_ERR;
      else if (!Tom && notas3 == NOTE_LA)
         word_cls = CLS_ADJ;
      else if (!Tom && notas3 == NOTE_SI)
         word_cls = CLS_ADV;
      else if (Tom && (notas3 == NOTE_DO || notas3 == NOTE_RE))
         word_cls = CLS_COMP;
      else
         word_cls = CLS_ERR;
   end

   always_comb begin
      seg_d = GLYPH_BLANK;
      unique case (word_cls)
         CLS_IDLE: seg_d = GLYPH_BLANK;
         CLS_ADJ:  seg_d = GLYPH_A;
         CLS_COMP: seg_d = GLYPH_C;
         CLS_ADV:  seg_d = GLYPH_D;
         CLS_ERR:  seg_d = GLYPH_E;
         default:  seg_d = GLYPH_E;
      endcase
      seg_d = seg_d ^ POL_MASK;
   end

   always_ff @(posedge clk) begin
      if (reset)
         seg_q <= SEG_RESET;
      else
         seg_q <= seg_d;
   end

   assign {saida1, saida2, saida3, saida4, saida5, saida6, saida7} = seg_q;

endmodule

// File: tb/tb_alfa_desc.sv
// tb_alfa_desc -- directed-vector bench for alfa_desc.
// Expected glyphs are hand-written active-high constants; the polarity mask
// follows ALFA_DESC_ACTIVE_LOW_EN so the same vectors cover both builds.

module tb_alfa_desc;

   logic       clk;
   logic       reset;
   logic       Tom;
   logic [2:0] notas1;
   logic [2:0] notas2;
   logic [2:0] notas3;
   logic       saida1, saida2, saida3, saida4, saida5, saida6, saida7;

   int unsigned n_total;
   int unsigned n_bad;

`ifdef ALFA_DESC_ACTIVE_LOW_EN
   localparam logic [6:0] POL = 7'b1111111;
`else
   localparam logic [6:0] POL = 7'b0000000;
`endif

   localparam logic [6:0] G_BLANK = 7'b0000000;
   localparam logic [6:0] G_A     = 7'b1110111;
   localparam logic [6:0] G_C     = 7'b1001110;
   localparam logic [6:0] G_D     = 7'b0111101;
   localparam logic [6:0] G_E     = 7'b1001111;

   alfa_desc u_dut (
      .clk    (clk),
      .reset  (reset),
      .Tom    (Tom),
      .notas1 (notas1),
      .notas2 (notas2),
      .notas3 (notas3),
      .saida1 (saida1),
      .saida2 (saida2),
      .saida3 (saida3),
      .saida4 (saida4),
      .saida5 (saida5),
      .saida6 (saida6),
      .saida7 (saida7)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] segs();
      return {saida1, saida2, saida3, saida4, saida5, saida6, saida7};
   endfunction

   task automatic check_seg(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%b want=%b", tag, got, exp);
      end
   endtask

   // Drive a vector just after an edge, let one edge pass, then sample.
   task automatic step(input string tag, input logic rst, input logic t,
                       input logic [2:0] n1, input logic [2:0] n2, input logic [2:0] n3,
                       input logic [6:0] glyph);
      reset  = rst;
      Tom    = t;
      notas1 = n1;
      notas2 = n2;
      notas3 = n3;
      @(posedge clk);
      #1;
      check_seg(tag, segs(), glyph ^ POL);
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      reset  = 1'b1;
      Tom    = 1'b0;
      notas1 = 3'b001;
      notas2 = 3'b010;
      notas3 = 3'b110;

      // Reset overrides an ADJ word, then ADJ appears one edge after release.
      step("reset_hold",  1'b1, 1'b0, 3'b001, 3'b010, 3'b110, G_BLANK);
      step("reset_hold2", 1'b1, 1'b0, 3'b001, 3'b010, 3'b110, G_BLANK);
      step("adj_release", 1'b0, 1'b0, 3'b001, 3'b010, 3'b110, G_A);

      // ADV then error on missing second note.
      step("adv",         1'b0, 1'b0, 3'b011, 3'b101, 3'b111, G_D);
      // Output is registered: new inputs must not show before the edge.
      Tom = 1'b0; notas1 = 3'b011; notas2 = 3'b000; notas3 = 3'b111;
      #2;
      check_seg("adv_hold", segs(), G_D ^ POL);
      step("err_n2_zero", 1'b0, 1'b0, 3'b011, 3'b000, 3'b111, G_E);

      // Comparatives and the error fallback with Tom=1.
      step("comp_do",     1'b0, 1'b1, 3'b001, 3'b001, 3'b001, G_C);
      step("comp_re",     1'b0, 1'b1, 3'b001, 3'b001, 3'b010, G_C);
      step("err_tom_la",  1'b0, 1'b1, 3'b001, 3'b001, 3'b110, G_E);
      step("err_tom_si",  1'b0, 1'b1, 3'b001, 3'b001, 3'b111, G_E);
      step("err_la_mi",   1'b0, 1'b0, 3'b001, 3'b001, 3'b011, G_E);
      step("err_n3_zero", 1'b0, 1'b0, 3'b100, 3'b110, 3'b000, G_E);

      // Idle and priority.
      step("idle_tom",    1'b0, 1'b1, 3'b000, 3'b000, 3'b000, G_BLANK);
      step("prio_n1",     1'b0, 1'b0, 3'b000, 3'b010, 3'b110, G_E);
      step("idle_notom",  1'b0, 1'b0, 3'b000, 3'b000, 3'b000, G_BLANK);
      step("prio_n2_adv", 1'b0, 1'b0, 3'b111, 3'b000, 3'b111, G_E);

      // Back-to-back: a new glyph every cycle, reset in the middle.
      step("b2b_idle",    1'b0, 1'b0, 3'b000, 3'b000, 3'b000, G_BLANK);
      step("b2b_adj",     1'b0, 1'b0, 3'b101, 3'b011, 3'b110, G_A);
      step("b2b_adv",     1'b0, 1'b0, 3'b110, 3'b111, 3'b111, G_D);
      step("b2b_reset",   1'b1, 1'b1, 3'b010, 3'b100, 3'b001, G_BLANK);
      step("b2b_comp",    1'b0, 1'b1, 3'b010, 3'b100, 3'b001, G_C);
      step("b2b_err",     1'b0, 1'b1, 3'b000, 3'b100, 3'b001, G_E);
      step("b2b_adj2",    1'b0, 1'b0, 3'b111, 3'b111, 3'b110, G_A);
      step("b2b_idle2",   1'b0, 1'b1, 3'b000, 3'b000, 3'b000, G_BLANK);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
